// File: rtl/cpu_io_pkg.sv
// Shared constants for the cpu I/O port block: register offsets above the port window.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package cpu_io_pkg;

  // Register offsets relative to NUM_PORTS; the out_p read-back window starts at RB_OFS.
  localparam int FLAGS_OFS = 0;
  localparam int MASK_OFS  = 1;
  localparam int RB_OFS    = 2;

  // Smallest address width that covers ports, FLAGS, MASK and the read-back window.
  function automatic int io_addr_w(input int num_ports);
    return $clog2(2 * num_ports + 2);
  endfunction

endpackage

// File: rtl/io_port_sync.sv
// One input port: SYNC_STAGES-deep synchroniser, previous-value register, gated change detect.
// Latency: pin to sync_o is SYNC_STAGES edges; chg_o follows one edge later via prev_q.
// Backpressure: none; samples every cycle.
module io_port_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             chg_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stg_q, stg_d;
  logic [WIDTH-1:0]                  prev_q;

  // Shift the pin value one stage deeper each cycle; stage 0 takes the raw pin.
  always_comb begin
    stg_d = {stg_q[SYNC_STAGES-2:0], in_i};
  end

  // Synchroniser chain and the previous synced value used for toggle detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_q  <= '0;
      prev_q <= '0;
    end else begin
      stg_q  <= stg_d;
      prev_q <= stg_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stg_q[SYNC_STAGES-1];
  assign chg_o  = en_i && (stg_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/cpu_io_ports.sv
// Memory-mapped I/O ports: synced inputs, output registers, sticky maskable change flags, irq.
// Latency: writes land at the strobe edge; rdata registered one cycle after re; irq is combinational.
// Backpressure: none; every single-cycle we/re strobe is accepted.
module cpu_io_ports
  import cpu_io_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       we,
  input  logic                       re,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  input  logic [NUM_PORTS*WIDTH-1:0] in_p,
  output logic [NUM_PORTS*WIDTH-1:0] out_p,
  output logic                       irq
);

  localparam int N       = NUM_PORTS;
  localparam int FLAGS_A = N + FLAGS_OFS;
  localparam int MASK_A  = N + MASK_OFS;
  localparam int RB_A    = N + RB_OFS;
  localparam int CW      = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME_MAX = CW'(SYNC_STAGES + 1);

  // Reject parameter sets the address map or synchroniser cannot support.
  if (ADDR_W < io_addr_w(NUM_PORTS)) begin : g_bad_addr_w
    $error("cpu_io_ports: ADDR_W too small for NUM_PORTS");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > WIDTH) begin : g_bad_ports
    $error("cpu_io_ports: NUM_PORTS must be 1..WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cpu_io_ports: SYNC_STAGES must be >= 2");
  end

  logic [N*WIDTH-1:0] sync_all;
  logic [N-1:0]       chg;
  logic               primed;

  logic [N*WIDTH-1:0] out_q, out_d;
  logic [N-1:0]       flags_q, flags_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]      prime_q, prime_d;

  for (genvar g = 0; g < N; g++) begin : g_port
    io_port_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (primed),
      .in_i   (in_p[g*WIDTH +: WIDTH]),
      .sync_o (sync_all[g*WIDTH +: WIDTH]),
      .chg_o  (chg[g])
    );
  end

  // Detection stays off until the synchronisers and prev registers hold real pin levels.
  assign primed = (prime_q == PRIME_MAX);

  // Next-state for the prime counter, register file, flags, mask and read data.
  always_comb begin
    int a;
    a       = int'(addr);
    prime_d = primed ? prime_q : prime_q + CW'(1);
    out_d   = out_q;
    mask_d  = mask_q;
    flags_d = flags_q;
    rdata_d = rdata_q;

    if (we) begin
      for (int i = 0; i < N; i++) begin
        if (a == i) out_d[i*WIDTH +: WIDTH] = wdata;
      end
      if (a == MASK_A)  mask_d  = wdata[N-1:0];
      if (a == FLAGS_A) flags_d = flags_q & ~wdata[N-1:0];
    end
    // Applied after the W1C so a same-cycle detection wins over the clear.
    flags_d = flags_d | chg;

    // Read mux uses current register values, so a same-cycle write is not visible yet.
    if (re) begin
      rdata_d = '0;
      for (int i = 0; i < N; i++) begin
        if (a == i)        rdata_d = sync_all[i*WIDTH +: WIDTH];
        if (a == RB_A + i) rdata_d = out_q[i*WIDTH +: WIDTH];
      end
      if (a == FLAGS_A) rdata_d[N-1:0] = flags_q;
      if (a == MASK_A)  rdata_d[N-1:0] = mask_q;
    end
  end

  // State registers; reset clears everything including pending flags and restarts priming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prime_q <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      flags_q <= '0;
      rdata_q <= '0;
    end else begin
      prime_q <= prime_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      flags_q <= flags_d;
      rdata_q <= rdata_d;
    end
  end

  assign out_p = out_q;
  assign rdata = rdata_q;
  assign irq   = |(flags_q & mask_q);

endmodule

// File: tb/tb_cpu_io_ports.sv
module tb_cpu_io_ports;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        we;
  logic        re;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [31:0] in_p;
  logic [31:0] out_p;
  logic        irq;

  int ntests = 0;
  int nfail  = 0;

  cpu_io_ports #(
    .NUM_PORTS   (4),
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .ADDR_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata),
    .in_p  (in_p),
    .out_p (out_p),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
  endtask

  initial begin
    addr  = '0;
    we    = 1'b0;
    re    = 1'b0;
    wdata = '0;
    in_p  = 32'h0000_0408;
    reset = 1'b0;

    // Reset with nonzero pins on ports 0 and 1
    tick();
    tick();
    chk("rst_out_p", 32'(out_p), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_irq",   32'(irq),   32'h0);
    reset = 1'b1;
    repeat (10) tick();
    rd(4'd4);
    chk("prime_flags", 32'(rdata), 32'h00);
    chk("prime_irq",   32'(irq),   32'h0);
    chk("prime_out_p", 32'(out_p), 32'h0);

    // Output port write and read-back
    wr(4'd2, 8'hA5);
    chk("wr_out_p", 32'(out_p), 32'h00A5_0000);
    rd(4'd8);
    chk("rb_port2", 32'(rdata), 32'hA5);
    rd(4'd0);
    chk("rd_in0", 32'(rdata), 32'h08);

    // Port 1 change 04 -> 05: sync after 2 edges, flag on the 3rd
    in_p[15:8] = 8'h05;
    rd(4'd4);
    chk("flag_early", 32'(rdata), 32'h00);
    rd(4'd1);
    chk("in1_old", 32'(rdata), 32'h04);
    rd(4'd1);
    chk("in1_new", 32'(rdata), 32'h05);
    rd(4'd4);
    chk("flag1_set", 32'(rdata), 32'h02);
    chk("irq_masked", 32'(irq), 32'h0);

    // Unmask raises irq, W1C drops it; upper mask bits are ignored
    wr(4'd5, 8'hF2);
    chk("irq_unmask", 32'(irq), 32'h1);
    rd(4'd5);
    chk("mask_rd", 32'(rdata), 32'h02);
    wr(4'd4, 8'h02);
    chk("irq_w1c", 32'(irq), 32'h0);
    rd(4'd4);
    chk("flags_w1c", 32'(rdata), 32'h00);

    // Port 1 change 05 -> 07 with W1C landing on the same edge as the set
    in_p[15:8] = 8'h07;
    tick();
    tick();
    wr(4'd4, 8'h02);
    rd(4'd4);
    chk("set_wins_flag", 32'(rdata), 32'h02);
    chk("set_wins_irq",  32'(irq),   32'h1);
    wr(4'd4, 8'h02);
    chk("clear_irq", 32'(irq), 32'h0);

    // Simultaneous read and write to MASK returns the pre-write value
    addr  = 4'd5;
    wdata = 8'h00;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we    = 1'b0;
    re    = 1'b0;
    chk("rw_same_old", 32'(rdata), 32'h02);
    rd(4'd5);
    chk("rw_same_new", 32'(rdata), 32'h00);

    // Unmapped address reads 0, writes have no effect
    rd(4'd15);
    chk("unmapped_rd", 32'(rdata), 32'h00);
    wr(4'd15, 8'hFF);
    chk("unmapped_wr_out", 32'(out_p), 32'h00A5_0000);
    rd(4'd5);
    chk("unmapped_wr_mask", 32'(rdata), 32'h00);
    rd(4'd4);
    chk("unmapped_wr_flags", 32'(rdata), 32'h00);

    // Port 0 write and read-back; read-back window write is ignored
    wr(4'd0, 8'h3C);
    wr(4'd9, 8'h77);
    chk("out_p_port0", 32'(out_p), 32'h00A5_003C);
    rd(4'd6);
    chk("rb_port0", 32'(rdata), 32'h3C);

    // Pending flag with irq high, then asynchronous reset mid-cycle
    wr(4'd5, 8'h01);
    in_p[7:0] = 8'h09;
    repeat (4) tick();
    chk("irq_port0", 32'(irq), 32'h1);
    rd(4'd6);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_p", 32'(out_p), 32'h0);
    chk("arst_rdata", 32'(rdata), 32'h0);
    chk("arst_irq",   32'(irq),   32'h0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    rd(4'd4);
    chk("reprime_flags", 32'(rdata), 32'h00);
    rd(4'd0);
    chk("reprime_in0", 32'(rdata), 32'h09);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/cpu_io_ports.md
Name: cpu_io_ports

Overview:
Parametrised memory-mapped I/O port block for the cpu core. It generalises the fixed p0..p3 8-bit port scheme to NUM_PORTS ports of WIDTH bits each. Each input port gets a synchroniser and per-port change detection. Change flags are sticky, maskable and combine into one interrupt line. The block sits between the CPU data bus (single-cycle read/write strobes) and the chip pins.

Parameters:
NUM_PORTS, 4, number of input ports and number of output ports; must be 1..WIDTH
WIDTH, 8, bits per port and data-bus width
SYNC_STAGES, 2, synchroniser flops per input bit; must be >= 2
ADDR_W, 4, CPU address width; must satisfy 2^ADDR_W >= 2*NUM_PORTS+2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
addr  input  ADDR_W  register address
we  input  1  write strobe, one cycle
re  input  1  read strobe, one cycle
wdata  input  WIDTH  write data
rdata  output  WIDTH  read data, registered
in_p  input  NUM_PORTS*WIDTH  asynchronous input pins, port i at bits [i*WIDTH +: WIDTH]
out_p  output  NUM_PORTS*WIDTH  output port registers, same packing
irq  output  1  OR of (flags & mask)

Behaviour:
- Reset (reset=0, asynchronous): out_p=0, rdata=0, flags=0, mask=0, all synchroniser and prev registers=0, prime counter=0, irq=0.
- Address map:
  - 0..N-1: read returns synced input port i; write loads out_p port i.
  - N: FLAGS. Read returns change flags in bits [N-1:0], upper bits 0. Write is write-1-to-clear.
  - N+1: MASK. Read/write, bits [N-1:0]; upper write bits ignored, read as 0.
  - N+2..2N+1: read-back of out_p port (addr-N-2); writes ignored.
  - Any other address: read returns 0, write has no effect.
- Write: takes effect at the clk edge where we=1; out_p changes the same edge.
- Read latency: rdata is valid the cycle after re=1. It holds its value when re=0.
- Read and write to the same address in the same cycle: rdata returns the pre-write value.
- we and re may both be asserted together; both are performed.
- Input path:
  - in_p passes through SYNC_STAGES flops, giving sync_i.
  - prev_i <= sync_i every cycle.
  - Change detected when sync_i != prev_i, i.e. any bit toggle on port i.
  - Input-to-readable latency: SYNC_STAGES cycles. Flag sets SYNC_STAGES+1 edges after the pin change.
- Priming:
  - A counter runs from 0 to SYNC_STAGES+1 after reset deassertion, then saturates.
  - Change detection is suppressed until the counter saturates, so reset-time pin levels raise no flags.
- Flags:
  - flag_i sets on detection and stays set until cleared by a W1C write.
  - Set and W1C clear of the same bit in the same cycle: set wins.
  - Repeated changes while the flag is set: no further effect.
- irq:
  - Combinational OR of registered (flags & mask); no other logic.
  - Writing mask=1 on an already-set flag raises irq the next cycle.
- Reset mid-operation: all state clears immediately, including pending flags. Priming restarts.

Decomposition:
- Package cpu_io_pkg:
  - Address offset constants FLAGS_OFS=0 and MASK_OFS=1, relative to NUM_PORTS.
  - RB_OFS=2.
  - Function io_addr_w(num_ports) for legal ADDR_W checking.
- Sub-module io_port_sync (WIDTH, SYNC_STAGES):
  - Contains the synchroniser, the prev register and the change output gated by an enable.
  - Instantiated NUM_PORTS times in a generate loop.
- The top level holds the register file, address decode, prime counter, flags/mask and the rdata register.

Test Plan (N=4, W=8, SYNC=2):
- Reset with in_p port0=8'h08, port1=8'h04, then release → out_p=0, irq=0, and FLAGS reads 8'h00 after 10 cycles (priming suppresses flags).
- Write addr 2 with 8'hA5 → out_p port2=8'hA5 at that edge. Read addr 8 (read-back) → rdata=8'hA5 one cycle after re.
- Change in_p port1 from 8'h04 to 8'h05 → addr 1 reads 8'h05 after 2 cycles; FLAGS=8'h02 after 3 edges; irq stays 0 with mask=0.
- Write MASK (addr 5)=8'h02 with flag1 set → irq=1 next cycle. W1C write of 8'h02 to addr 4 → flags=0 and irq=0 next cycle.
- W1C of bit1 in the same cycle as a new port1 change → flag1 remains 1 (set wins).
- Read addr 15 → rdata=0. Write addr 15 → no change to any register. Assert reset mid-sequence → all outputs 0 asynchronously, before the next clk edge.
